// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the memory responders: FSM encodings, field widths, address check.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package data_mem_responder_pkg;

  // Responder FSM encodings; the instruction-memory responder uses the same ones.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W  = 4;   // latency counter width, covers LATENCY up to 15
  localparam int BE_W   = 4;   // byte lanes per 32-bit word
  localparam int DATA_W = 32;

  // A request is rejected if it is misaligned, below the window base, or beyond
  // the last word. The subtract is 32-bit unsigned, so addresses below base wrap
  // to a huge index; the explicit addr < base test keeps that case obvious.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    return (addr[1:0] != 2'b00) || (addr < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array_be.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
// Latency: read data valid the cycle after an enabled access edge.
// Backpressure: none; the caller decides when to enable an access.
// Ports: clk; en (access this edge); we (write); be (byte lanes); addr (word index);
//        wdata (store data); rdata (word read at the last enabled edge, pre-write value).
module mem_array_be
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // No reset on the array or its read register: contents survive responder reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MIPS load/store port: one word request at a time.
// Latency: response valid LATENCY cycles after the request cycle; array touched on entry to RESP.
// Backpressure: req_ready low from accept until response handshake; rsp held while rsp_ready=0.
// Ports: clk, reset (async, active low); req_valid/req_ready/req_we/req_addr/req_wdata/req_be
//        request side; rsp_valid/rsp_ready/rsp_rdata/rsp_err response side.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1    = CNT_W'(LATENCY - 1);
  localparam logic [31:0]      DEPTH_W32 = 32'(DEPTH_WORDS);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, err_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic                accept;
  logic                ram_en;
  logic                req_err;
  logic [IDX_W-1:0]    req_idx;
  logic                sel_we, sel_err;
  logic [IDX_W-1:0]    sel_idx;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   ram_rdata;

  assign req_err = addr_err(req_addr, BASE_ADDR, DEPTH_W32);
  assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ram_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = LAT_M1;
          if (LATENCY == 1) begin
            state_d = S_RESP;
            ram_en  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          ram_en  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With LATENCY==1 the array is accessed on the accept edge itself, before the
  // latch holds the request, so the live request fields feed the RAM in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_we    = req_we;
      sel_err   = req_err;
      sel_idx   = req_idx;
      sel_wdata = req_wdata;
      sel_be    = req_be;
    end else begin
      sel_we    = we_q;
      sel_err   = err_q;
      sel_idx   = idx_q;
      sel_wdata = wdata_q;
      sel_be    = be_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  mem_array_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (IDX_W)
  ) u_mem (
    .clk   (clk),
    .en    (ram_en),
    .we    (sel_we && !sel_err),
    .be    (sel_be),
    .addr  (sel_idx),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // Outputs decode from state only, so reset clears them without a clock edge.
  // The RAM read register is only reloaded on RESP entry, so data holds under backpressure.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory as a plain word array with a per-word "known" flag; a transaction is
  // pending from accept until its response handshake and its response becomes
  // visible LAT cycles after the request cycle.
  logic [31:0] mmem   [DEPTH];
  bit          mknown [DEPTH];
  bit          m_pend = 0;
  int          m_cyc  = 0;
  bit          m_we, m_err, m_rknown;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  function automatic bit spec_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (a < BASE) || ((off / 4) >= DEPTH);
  endfunction

  task automatic m_apply();
    int w;
    m_rdata  = 32'h0;
    m_rknown = 1'b1;
    if (!m_err) begin
      w = int'((m_addr - BASE) / 4);
      if (m_we) begin
        if (mknown[w]) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mmem[w][8*b +: 8] = m_wdata[8*b +: 8];
        end else if (m_be == 4'hF) begin
          mmem[w]   = m_wdata;
          mknown[w] = 1'b1;
        end
      end else begin
        m_rknown = mknown[w];
        m_rdata  = mknown[w] ? mmem[w] : 32'h0;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0;
    end else if (m_pend) begin
      if (m_cyc >= LAT - 1) begin
        if (rsp_ready) m_pend = 1'b0;
      end else begin
        m_cyc++;
        if (m_cyc == LAT - 1) m_apply();
      end
    end else if (req_valid) begin
      m_pend  = 1'b1;
      m_cyc   = 0;
      m_we    = req_we;
      m_addr  = req_addr;
      m_wdata = req_wdata;
      m_be    = req_be;
      m_err   = spec_err(req_addr);
      if (LAT == 1) m_apply();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit ev;
    if (reset) begin
      ev = m_pend && (m_cyc >= LAT - 1);
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_pend});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
      if (ev) begin
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
        if (m_rknown) chk("rsp_rdata", rsp_rdata, m_rdata);
      end else begin
        chk("idle_rdata", rsp_rdata, 32'h0);
        chk("idle_err", {31'b0, rsp_err}, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  // One complete transaction: request, wait for response, hold off rsp_ready
  // for 'hold' cycles (optionally driving junk requests), then handshake.
  task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input bit noise,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    // Post-accept changes to the request fields must not leak into this transaction.
    req_valid = noise; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = $urandom; req_be = 4'hF;
    lat = 0; rdata = 32'h0; err = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat > 40) begin
        chk("rsp_timeout", {31'b0, rsp_valid}, 32'h1);
        req_valid = 1'b0;
        return;
      end
    end
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      if (noise) req_wdata = $urandom;
      @(negedge clk);
      if (noise) begin
        chk("bp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
      end
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    #22 reset = 1'b1;

    // Store then load, latency check
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lt);
    chk("st10_lat", lt, LAT);
    chk("st10_err", {31'b0, er}, 32'h0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("ld10_lat", lt, LAT);
    chk("ld10_data", rd, 32'hDEADBEEF);

    // Byte enables
    xfer(1, 32'h20, 32'h11223344, 4'hF, 1, 0, rd, er, lt);
    xfer(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, lt);
    xfer(0, 32'h20, 32'h0, 4'h0, 2, 0, rd, er, lt);
    chk("be_merge", rd, 32'h11BB33DD);

    // Errors and the be=0 no-op store
    xfer(1, 32'h0, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lt);
    xfer(0, 32'h13, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("mis_err", {31'b0, er}, 32'h1);
    chk("mis_rdata", rd, 32'h0);
    chk("mis_lat", lt, LAT);
    xfer(1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lt);
    chk("oor_err", {31'b0, er}, 32'h1);
    xfer(0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("word0_kept", rd, 32'h0BADF00D);
    chk("word0_err", {31'b0, er}, 32'h0);
    xfer(1, 32'h10, 32'h12345678, 4'h0, 0, 0, rd, er, lt);
    chk("be0_err", {31'b0, er}, 32'h0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("be0_noop", rd, 32'hDEADBEEF);

    // Backpressure with junk requests present
    xfer(0, 32'h20, 32'h0, 4'h0, 5, 1, rd, er, lt);
    chk("bp_rdata", rd, 32'h11BB33DD);
    xfer(0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("bp_no_junk_write", rd, 32'h11BB33DD);

    // Reset during WAIT on a store
    xfer(1, 32'h30, 32'h5, 4'hF, 0, 0, rd, er, lt);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77; req_be = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("rstw_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rstw_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk); #3 reset = 1'b1;
    xfer(0, 32'h30, 32'h0, 4'h0, 0, 0, rd, er, lt);
    chk("rstw_store_lost", rd, 32'h5);

    // Reset while an errored response is being held
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h13;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    chk("rstr_pre_err", {31'b0, rsp_err}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstr_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rstr_err", {31'b0, rsp_err}, 32'h0);
    chk("rstr_rdata", rsp_rdata, 32'h0);
    @(negedge clk); #3 reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 63)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h400 + 32'($urandom_range(0, 15)) * 4;
      else               a = 32'hFFFF_FFFC;
      xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er, lt);
      chk("rand_lat", lt, LAT);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
